// File: rtl/ram_rr_arbiter_pkg.sv
// Shared widths and helpers for the RAM port round-robin arbiter.
// Defaults match the 16x8 dual_port_sync_ram.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DEPTH  = 16;

    // Smallest r with 2**r >= value; used to size requester indices.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around one arbitrated RAM port.
// The arbiter uses the slave modport; clients plus the RAM use the master modport.
interface ram_rr_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W,
    parameter int ID_W    = clog2(NUM_REQ)
);

    // Handshake: requester i raises req[i] and holds req/we/addr/wdata stable
    // until it sees gnt[i]; the transfer happens on the clk edge where
    // req[i] & gnt[i]. A read answers one cycle later with rd_valid/rd_id.
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;

    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_din;
    logic [DATA_W-1:0]         ram_dout;

    logic                      rd_valid;
    logic [ID_W-1:0]           rd_id;
    logic [DATA_W-1:0]         rd_data;

    logic [ID_W-1:0]           dbg_ptr;

    modport master (
        output req, req_we, req_addr, req_wdata, ram_dout,
        input  gnt, ram_we, ram_addr, ram_din, rd_valid, rd_id, rd_data, dbg_ptr
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, ram_dout,
        output gnt, ram_we, ram_addr, ram_din, rd_valid, rd_id, rd_data, dbg_ptr
    );

endinterface

// File: rtl/ram_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: the first requester at or after ptr,
// wrapping modulo NUM_REQ, wins.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    // Step k visits requester (ptr+k) mod NUM_REQ; comparing ptr against a
    // constant keeps every select static and avoids power-of-two wrap tricks.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (ptr == ID_W'((i + NUM_REQ - k) % NUM_REQ))) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among NUM_REQ clients;
// read data returns tagged with the requester index one cycle after the grant.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input logic            clk,
    input logic            rst,
    ram_rr_arbiter_if.slave bus
);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_found;
    logic               grant_ok;
    logic               rd_pend;
    logic [ID_W-1:0]    rd_id_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign grant_ok = pick_found & ~rst;
    assign ptr_next = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

    // Idle port issues a harmless read of address 0.
    always_comb begin
        bus.gnt      = '0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (grant_ok) begin
            bus.gnt = pick_gnt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick_gnt[i]) begin
                    bus.ram_we   = bus.req_we[i];
                    bus.ram_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                    bus.ram_din  = bus.req_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            rd_pend <= 1'b0;
            rd_id_q <= '0;
        end else begin
            rd_pend <= 1'b0;
            if (pick_found) begin
                ptr <= ptr_next;
                if (!bus.ram_we) begin
                    rd_pend <= 1'b1;
                    rd_id_q <= pick_idx;
                end
            end
        end
    end

    assign bus.rd_valid = rd_pend;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_data  = rd_pend ? bus.ram_dout : '0;
    assign bus.dbg_ptr  = ptr;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios then randomized traffic, each
// cycle compared against a priority-scan reference model and a memory image.
module tb_ram_rr_arbiter;
    import ram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

    ram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- requester drive ----------------
    logic [N-1:0]  r_req;
    logic [N-1:0]  r_we;
    logic [AW-1:0] r_addr  [N];
    logic [DW-1:0] r_wdata [N];

    assign bus.req    = r_req;
    assign bus.req_we = r_we;
    always_comb begin
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = r_addr[i];
            bus.req_wdata[i*DW +: DW] = r_wdata[i];
        end
    end

    // ---------------- synchronous RAM port ----------------
    logic          preload = 1'b1;
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 16; a++) ram_mem[a] <= DW'(8'h10 + a);
        end else if (bus.ram_we) begin
            ram_mem[bus.ram_addr] <= bus.ram_din;
        end
        ram_q <= ram_mem[bus.ram_addr];
    end
    assign bus.ram_dout = ram_q;

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] model_mem [16];
    logic [DW-1:0] exp_q [$];
    int            m_ptr;
    logic          exp_valid;
    logic [IW-1:0] exp_id;
    int            wait_cnt [N];
    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            cyc = 0;
    int            last_g0;
    bit            hold_mode = 1'b0;
    bit            random_mode = 1'b0;

    function automatic logic [IW-1:0] ix(input int v);
        return IW'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic rand_fields(input int i);
        r_we[ix(i)]    = 1'($urandom_range(0, 1));
        r_addr[ix(i)]  = AW'($urandom_range(0, 15));
        r_wdata[ix(i)] = DW'($urandom_range(0, 255));
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (v) begin
            m_ptr     = 0;
            exp_valid = 1'b0;
            exp_id    = '0;
            exp_q.delete();
        end
    endtask

    // ---------------- driver: one checked clock cycle ----------------
    task automatic step(input string phase);
        int            w;
        int            j;
        logic [N-1:0]  eg;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] edata;
        @(negedge clk);
        w = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && r_req[ix(j)]) w = j;
            end
        end
        eg = '0; ewe = 1'b0; ea = '0; ed = '0;
        if (w >= 0) begin
            eg[ix(w)] = 1'b1;
            ewe = r_we[ix(w)];
            ea  = r_addr[ix(w)];
            ed  = r_wdata[ix(w)];
        end
        edata = (exp_valid && exp_q.size() > 0) ? exp_q[0] : '0;
        chk({phase, ".gnt"},      32'(bus.gnt),      32'(eg));
        chk({phase, ".ram_we"},   32'(bus.ram_we),   32'(ewe));
        chk({phase, ".ram_addr"}, 32'(bus.ram_addr), 32'(ea));
        chk({phase, ".ram_din"},  32'(bus.ram_din),  32'(ed));
        chk({phase, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_valid));
        chk({phase, ".rd_id"},    32'(bus.rd_id),    32'(exp_id));
        chk({phase, ".rd_data"},  32'(bus.rd_data),  32'(edata));
        chk({phase, ".ptr"},      32'(bus.dbg_ptr),  32'(m_ptr));
        @(posedge clk);
        #1;
        cyc++;
        if (exp_valid && exp_q.size() > 0) void'(exp_q.pop_front());
        exp_valid = 1'b0;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (r_req[ix(i)] && i != w) wait_cnt[i]++;
            end
        end
        if (w >= 0) begin
            chk({phase, ".fair"}, 32'(wait_cnt[w] < N), 32'd1);
            wait_cnt[w] = 0;
            if (ewe) begin
                model_mem[ea] = ed;
            end else begin
                exp_q.push_back(model_mem[ea]);
                exp_valid = 1'b1;
                exp_id    = ix(w);
            end
            m_ptr = (w + 1) % N;
            if (w == 0 && hold_mode) begin
                if (last_g0 >= 0) chk({phase, ".gap0"}, 32'(cyc - last_g0), 32'(N));
                last_g0 = cyc;
            end
            if (hold_mode) begin
                rand_fields(w);
            end else if (random_mode) begin
                r_req[ix(w)] = 1'($urandom_range(0, 1));
                rand_fields(w);
            end else begin
                r_req[ix(w)] = 1'b0;
            end
        end
        if (random_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!r_req[ix(i)] && $urandom_range(0, 2) == 0) begin
                    r_req[ix(i)] = 1'b1;
                    rand_fields(i);
                end else if (r_req[ix(i)] && i != w && $urandom_range(0, 15) == 0) begin
                    r_req[ix(i)] = 1'b0;
                    wait_cnt[i]  = 0;
                end
            end
        end
    endtask

    // ---------------- directed then random sequence ----------------
    initial begin
        for (int a = 0; a < 16; a++) model_mem[a] = DW'(8'h10 + a);
        for (int i = 0; i < N; i++) begin
            r_we[ix(i)]    = 1'b0;
            r_addr[ix(i)]  = AW'(i);
            r_wdata[ix(i)] = '0;
            wait_cnt[i]    = 0;
        end
        r_req   = 4'b1111;
        last_g0 = -1;
        set_rst(1'b1);

        // Reset holds everything quiet even with all requests up.
        step("rst");
        step("rst");
        preload = 1'b0;
        set_rst(1'b0);

        // All four read addrs 0..3: grants 0,1,2,3 and data 0x10..0x13.
        repeat (4) step("all_rd");
        step("all_rd_ret");

        // Requester 1 writes 0xAA to addr 2, then reads it back.
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 4'd2; r_wdata[1] = 8'hAA;
        step("w1");
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 4'd2;
        step("r1");
        step("r1_ret");

        // Pointer wrap: grant 2 leaves ptr=3, then 1001 grants 3 then 0.
        r_req[2] = 1'b1; r_we[2] = 1'b0; r_addr[2] = 4'd7;
        step("wrap2");
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 4'd3;
        r_req[3] = 1'b1; r_we[3] = 1'b0; r_addr[3] = 4'd2;
        step("wrap3");
        step("wrap0");
        step("wrap_ret");

        // Reset right after a read grant drops the pending return.
        r_req[2] = 1'b1; r_we[2] = 1'b0; r_addr[2] = 4'd5;
        step("mrd");
        set_rst(1'b1);
        step("mrd_rst");
        set_rst(1'b0);
        step("mrd_post");

        // Everyone holds requests: requester 0 every 4th cycle.
        hold_mode = 1'b1;
        last_g0   = -1;
        for (int i = 0; i < N; i++) begin
            r_req[ix(i)] = 1'b1;
            rand_fields(i);
        end
        repeat (16) step("fair");
        hold_mode = 1'b0;

        // Randomized traffic with occasional resets and withdrawals.
        random_mode = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 79) == 0) begin
                set_rst(1'b1);
                step("rnd_rst");
                set_rst(1'b0);
            end
            step("rnd");
        end
        random_mode = 1'b0;
        r_req = '0;
        step("drain");
        step("drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Round-robin arbiter that shares one port of the 16x8 dual_port_sync_ram among NUM_REQ requesters.
- Grants at most one request per cycle and drives the RAM port (we/addr/din) combinationally from the winner.
- Returns read data with requester ID one cycle after the read is granted, matching the RAM's 1-cycle registered read.
- Sits between client blocks and RAM port A or B; one instance per port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- ID_W, 2, requester index width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, held until granted.
- req_we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read).
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data; same slicing.
- gnt  out  NUM_REQ  one-hot grant, combinational; transfer occurs on a clk edge where req[i]&gnt[i].
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din.
- ram_dout  in  DATA_W  from RAM dout.
- rd_valid  out  1  read data valid.
- rd_id  out  ID_W  requester index of the returned read.
- rd_data  out  DATA_W  read data.

Behaviour:
- State
  - ptr (ID_W bits): highest-priority requester index.
  - rd_pend (1 bit) and rd_id (ID_W bits) registers.
- Reset (async, rst=1)
  - ptr=0, rd_valid=0, rd_id=0.
  - While rst=1: gnt=0, ram_we=0, ram_addr=0, ram_din=0.
- Grant (combinational, rst=0)
  - Scan requesters ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - First i with req[i]=1 gets gnt[i]=1. All others 0.
- RAM drive
  - With a grant: ram_we=req_we[i], ram_addr=req_addr slice i, ram_din=req_wdata slice i.
  - With no grant: ram_we=0, ram_addr=0, ram_din=0, so the RAM performs a harmless read of address 0.
- Pointer update on each clk edge
  - If grant to i: ptr <= (i+1) mod NUM_REQ. Wrap: i=NUM_REQ-1 → ptr=0.
  - No grant: ptr holds.
- Read return
  - If granted and req_we[i]=0: rd_valid <= 1, rd_id <= i. Otherwise rd_valid <= 0.
  - rd_data = rd_valid ? ram_dout : 0.
  - Latency: exactly 1 cycle from grant edge to rd_valid high.
  - Back-to-back reads give rd_valid on consecutive cycles.
- Writes: no response. Complete at the grant edge.
- Fairness: a requester holding req continuously is granted within NUM_REQ cycles.
- Simultaneous requests: exactly one grant. The rest stay pending, and requesters must hold req, we, addr and wdata stable until granted.
- Read-after-write, same address, consecutive grants: the read returns the new data, since the write has committed before the read edge.
- Cross-port collisions with the other RAM port are outside this block's scope.
- Reset mid-read: a read granted before rst rises is dropped; rd_valid stays 0 after release.
- req deasserted before grant: request withdrawn, no side effects.
- NUM_REQ not a power of two: ptr wrap uses explicit compare, never bit truncation.

Decomposition:
- Package ram_arb_pkg
  - Default widths: RAM_ADDR_W=4, RAM_DATA_W=8, RAM_DEPTH=16.
  - Function clog2 for ID_W derivation.
- Sub-module rr_pick
  - Pure combinational rotate-priority encoder.
  - Inputs: req vector, ptr. Outputs: one-hot gnt, encoded index, any-grant flag.
- Top level holds the ptr/read-return registers and the RAM muxes.

Test Plan (NUM_REQ=4, ADDR_W=4, DATA_W=8, connected to dual_port_sync_ram port A):
- Reset with req=4'b1111 → gnt=0, rd_valid=0 during reset. First cycle after release: gnt=4'b0001.
- Requester 1 writes 0xAA to addr 2, then reads addr 2 → gnt[1] on each request; rd_valid=1, rd_id=1, rd_data=0xAA one cycle after the read grant.
- All four hold read requests to addrs 0..3 (preloaded 0x10..0x13) → grants in order 0,1,2,3 on consecutive cycles; rd_data 0x10..0x13 with rd_id 0..3.
- Wrap: ptr=3 after granting 2, with req=4'b1001 → grant 3, then 0; ptr returns to 1.
- Assert rst one cycle after a read grant to requester 2 → rd_valid never rises for that read; ptr=0 after release.
- Requester 0 requests continuously while 1..3 also request → requester 0 granted exactly every 4th cycle; no requester waits more than 4 cycles.
